// File: rtl/adc_conv_ctrl_if.sv
// Command/response stream bundle for the ADC conversion controller.
// master issues commands and consumes results; slave is the controller.
interface adc_conv_ctrl_if;
  logic        command_valid;
  logic [4:0]  command_channel;
  logic        command_startofpacket;
  logic        command_endofpacket;
  logic        command_ready;
  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic        response_startofpacket;
  logic        response_endofpacket;

  modport master (
    output command_valid, command_channel,
    output command_startofpacket, command_endofpacket,
    input  command_ready,
    input  response_valid, response_channel, response_data,
    input  response_startofpacket, response_endofpacket
  );

  modport slave (
    input  command_valid, command_channel,
    input  command_startofpacket, command_endofpacket,
    output command_ready,
    output response_valid, response_channel, response_data,
    output response_startofpacket, response_endofpacket
  );
endinterface

// File: rtl/adc_conv_ctrl.sv
// ADC conversion controller: samples a channel on accept, times the
// conversion with a divided tick, then emits a one-cycle result strobe.
module adc_conv_ctrl #(
  parameter int NUM_CH     = 9,
  parameter int CLK_DIV    = 25,
  parameter int CONV_TICKS = 4
) (
  input  logic                   clock_clk,
  input  logic                   reset_sink_reset_n,
  input  logic                   adc_pll_locked_export,
  input  logic [NUM_CH*12-1:0]   ch_data,
  adc_conv_ctrl_if.slave         st
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int TICK_W = $clog2(CONV_TICKS + 1);
  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CONV_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    RESPOND
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [4:0]          lat_ch;
  logic [11:0]         lat_data;
  logic                lat_sop;
  logic                lat_eop;
  logic                rsp_valid;
  logic [4:0]          rsp_ch;
  logic [11:0]         rsp_data;
  logic                rsp_sop;
  logic                rsp_eop;
  logic [11:0]         sample;
  logic                ready;

  // Out-of-range channels fall through to zero
  always_comb begin
    sample = 12'h000;
    for (int i = 0; i < NUM_CH; i++) begin
      if (st.command_channel == 5'(i))
        sample = ch_data[i*12 +: 12];
    end
  end

  // Ready is forced low while reset is held so every output reads 0
  assign ready = reset_sink_reset_n
               & adc_pll_locked_export
               & (state == IDLE);

  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      lat_ch    <= '0;
      lat_data  <= '0;
      lat_sop   <= 1'b0;
      lat_eop   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_ch    <= '0;
      rsp_data  <= '0;
      rsp_sop   <= 1'b0;
      rsp_eop   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (st.command_valid && ready) begin
            lat_ch   <= st.command_channel;
            lat_data <= sample;
            lat_sop  <= st.command_startofpacket;
            lat_eop  <= st.command_endofpacket;
            div_cnt  <= '0;
            tick_cnt <= '0;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          if (!adc_pll_locked_export) begin
            state <= IDLE;
          end else if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
            if (tick_cnt == TICK_LAST) begin
              state     <= RESPOND;
              rsp_valid <= 1'b1;
              rsp_ch    <= lat_ch;
              rsp_data  <= lat_data;
              rsp_sop   <= lat_sop;
              rsp_eop   <= lat_eop;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign st.command_ready          = ready;
  assign st.response_valid         = rsp_valid;
  assign st.response_channel       = rsp_ch;
  assign st.response_data          = rsp_data;
  assign st.response_startofpacket = rsp_sop;
  assign st.response_endofpacket   = rsp_eop;

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Scoreboard bench for adc_conv_ctrl: accepts are modelled at the
// handshake, results popped and checked on each response strobe.
module tb_adc_conv_ctrl;
  localparam int NUM_CH = 9;
  localparam int LAT    = 101;
  localparam int PERIOD = 102;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 locked = 1'b0;
  logic [NUM_CH*12-1:0] ch_data = '0;
  int                   cyc = 0;
  int                   checks = 0;
  int                   errors = 0;

  typedef struct {
    logic [4:0]  ch;
    logic [11:0] data;
    logic        sop;
    logic        eop;
    int          due;
  } exp_t;

  exp_t sb[$];

  adc_conv_ctrl_if bus();

  adc_conv_ctrl dut (
    .clock_clk             (clk),
    .reset_sink_reset_n    (rst_n),
    .adc_pll_locked_export (locked),
    .ch_data               (ch_data),
    .st                    (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] model(input logic [4:0] ch);
    logic [NUM_CH*12-1:0] d;
    d = ch_data;
    if (int'(ch) < NUM_CH) return d[int'(ch)*12 +: 12];
    return 12'h000;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.command_valid && bus.command_ready) begin
      e.ch   = bus.command_channel;
      e.data = model(bus.command_channel);
      e.sop  = bus.command_startofpacket;
      e.eop  = bus.command_endofpacket;
      e.due  = cyc + LAT;
      sb.push_back(e);
    end
    if (bus.response_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_response ch=%0d data=%h at cyc %0d",
                 bus.response_channel, bus.response_data, cyc);
      end else begin
        e = sb.pop_front();
        if ({bus.response_channel, bus.response_data,
             bus.response_startofpacket, bus.response_endofpacket}
            !== {e.ch, e.data, e.sop, e.eop} || cyc != e.due) begin
          errors++;
          $display("FAIL response got ch=%0d d=%h s=%b e=%b cyc=%0d want ch=%0d d=%h s=%b e=%b cyc=%0d",
                   bus.response_channel, bus.response_data,
                   bus.response_startofpacket, bus.response_endofpacket, cyc,
                   e.ch, e.data, e.sop, e.eop, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] ch, input logic sop, input logic eop);
    int n;
    n = 0;
    bus.command_valid         = 1'b1;
    bus.command_channel       = ch;
    bus.command_startofpacket = sop;
    bus.command_endofpacket   = eop;
    @(negedge clk);
    while (!bus.command_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL send_timeout ready=%b required 1", bus.command_ready);
    end
    tick();
    bus.command_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    bus.command_valid         = 1'b1;
    bus.command_channel       = 5'd0;
    bus.command_startofpacket = 1'b0;
    bus.command_endofpacket   = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.command_ready, bus.response_valid, bus.response_channel,
         bus.response_data, bus.response_startofpacket,
         bus.response_endofpacket} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero required 0");
    end
    rst_n = 1'b1;
    repeat (500) begin
      tick();
      if (bus.command_ready !== 1'b0 || bus.response_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL unlocked_idle bad_cycles=%0d required 0", bad);
    end
    bus.command_valid = 1'b0;
  endtask

  task automatic test_single();
    locked = 1'b1;
    ch_data[11:0] = 12'hABC;
    tick();
    send(5'd0, 1'b1, 1'b1);
    ch_data[11:0] = 12'h000;
    drain();
    tick();
    checks++;
    if (bus.response_valid !== 1'b0 || bus.response_data !== 12'hABC ||
        bus.response_channel !== 5'd0) begin
      errors++;
      $display("FAIL response_hold got v=%b d=%h required v=0 d=abc",
               bus.response_valid, bus.response_data);
    end
  endtask

  task automatic test_back_to_back();
    int last;
    int n;
    last = 0;
    ch_data[11:0] = 12'h100;
    bus.command_valid         = 1'b1;
    bus.command_channel       = 5'd0;
    bus.command_startofpacket = 1'b1;
    bus.command_endofpacket   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (!bus.response_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 200) begin
        errors++;
        $display("FAIL b2b_timeout resp %0d", k);
      end else if (k > 0 && cyc - last != PERIOD) begin
        errors++;
        $display("FAIL b2b_period got %0d required %0d", cyc - last, PERIOD);
      end
      last = cyc;
      tick();
      ch_data[11:0] = ch_data[11:0] + 12'h001;
    end
    bus.command_valid = 1'b0;
    drain();
  endtask

  task automatic test_channels();
    ch_data[3*12 +: 12] = 12'h123;
    send(5'd3, 1'b1, 1'b0);
    drain();
    send(5'd12, 1'b0, 1'b1);
    drain();
    tick();
    checks++;
    if (bus.response_channel !== 5'd12 || bus.response_data !== 12'h000) begin
      errors++;
      $display("FAIL out_of_range_hold got ch=%0d d=%h required ch=12 d=000",
               bus.response_channel, bus.response_data);
    end
  endtask

  task automatic test_lock_loss();
    int bad;
    bad = 0;
    ch_data[1*12 +: 12] = 12'h5A5;
    send(5'd1, 1'b1, 1'b1);
    repeat (40) tick();
    locked = 1'b0;
    sb.delete();
    repeat (200) begin
      tick();
      if (bus.command_ready !== 1'b0 || bus.response_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lock_abort bad_cycles=%0d required 0", bad);
    end
    locked = 1'b1;
    #1;
    checks++;
    if (bus.command_ready !== 1'b1) begin
      errors++;
      $display("FAIL relock_ready got %b required 1", bus.command_ready);
    end
    tick();
    send(5'd1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    ch_data[2*12 +: 12] = 12'h777;
    send(5'd2, 1'b1, 1'b0);
    repeat (60) tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({bus.command_ready, bus.response_valid, bus.response_channel,
         bus.response_data, bus.response_startofpacket,
         bus.response_endofpacket} !== '0) begin
      errors++;
      $display("FAIL async_reset got d=%h ch=%0d required 0",
               bus.response_data, bus.response_channel);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    send(5'd2, 1'b0, 1'b1);
    drain();
  endtask

  initial begin
    bus.command_valid         = 1'b0;
    bus.command_channel       = 5'd0;
    bus.command_startofpacket = 1'b0;
    bus.command_endofpacket   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_channels();
    test_lock_loss();
    test_reset_mid();
    repeat (150) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_queue pending=%0d required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
